// File: rtl/seq_serializer_pkg.sv
// seq_serializer shared types and constants.
// State encoding and word counter width.
package seq_serializer_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam int N_DEF = 16;
  localparam int WC_W  = 8;

endpackage

// File: rtl/seq_serializer_if.sv
// Load handshake and serial output bundle
// for seq_serializer.
interface seq_serializer_if
  import seq_serializer_pkg::*;
#(
  parameter int N = N_DEF
);

  logic            load_valid;
  logic [N-1:0]    load_data;
  logic            load_ready;
  logic            shift_en;
  logic            bit_out;
  logic            bit_valid;
  logic            last_bit;
  logic [WC_W-1:0] word_count;

  modport master (
    output load_valid,
    output load_data,
    output shift_en,
    input  load_ready,
    input  bit_out,
    input  bit_valid,
    input  last_bit,
    input  word_count
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  shift_en,
    output load_ready,
    output bit_out,
    output bit_valid,
    output last_bit,
    output word_count
  );

endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end, MSB first,
// with a one-word holding register.
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int N = N_DEF
) (
  input logic             clk,
  input logic             rst,
  seq_serializer_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          st, st_n;
  logic [N-1:0]    sh, sh_n;
  logic [N-1:0]    hold, hold_n;
  logic            hf, hf_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [WC_W-1:0] wc, wc_n;

  logic accept;
  logic consume;
  logic at_last;

  assign accept  = bus.load_valid && !hf;
  assign consume = bus.shift_en && (st == S_SHIFT);
  assign at_last = (cnt == LAST);

  // State, shifter, hold and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= S_IDLE;
      sh   <= '0;
      hold <= '0;
      hf   <= 1'b0;
      cnt  <= '0;
      wc   <= '0;
    end else begin
      st   <= st_n;
      sh   <= sh_n;
      hold <= hold_n;
      hf   <= hf_n;
      cnt  <= cnt_n;
      wc   <= wc_n;
    end
  end

  // Next state: load, shift, refill from hold.
  always_comb begin
    st_n   = st;
    sh_n   = sh;
    hold_n = hold;
    hf_n   = hf;
    cnt_n  = cnt;
    wc_n   = wc;
    unique case (st)
      S_IDLE: begin
        if (accept) begin
          sh_n  = bus.load_data;
          cnt_n = '0;
          st_n  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (consume && at_last) begin
          wc_n = wc + WC_W'(1);
          if (hf) begin
            sh_n  = hold;
            hf_n  = 1'b0;
            cnt_n = '0;
          end else if (accept) begin
            sh_n  = bus.load_data;
            cnt_n = '0;
          end else begin
            st_n = S_IDLE;
          end
        end else begin
          if (consume) begin
            sh_n  = {sh[N-2:0], 1'b0};
            cnt_n = cnt + CW'(1);
          end
          if (accept) begin
            hold_n = bus.load_data;
            hf_n   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.load_ready = !hf;
  assign bus.bit_out    = sh[N-1];
  assign bus.bit_valid  = (st == S_SHIFT);
  assign bus.last_bit   = (st == S_SHIFT) && at_last;
  assign bus.word_count = wc;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer:
// vector table plus multi-cycle sequences.
module tb_seq_serializer;

  typedef struct {
    logic        lv;
    logic [15:0] d;
    logic        se;
    logic        ebo;
    logic        ebv;
    logic        elast;
    logic        erdy;
    logic [7:0]  ewc;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_serializer_if #(.N(16)) bus();

  seq_serializer #(.N(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lv,
                       input logic [15:0] d,
                       input logic se);
    bus.load_valid = lv;
    bus.load_data  = d;
    bus.shift_en   = se;
  endtask

  vec_t        vecs[17];
  int          exp_bits[16];
  logic [15:0] w0;
  logic [15:0] w1;
  int          pos;
  int          stalls;
  int          acc;
  int          lasts;
  int          gaps;
  bit          seen;
  bit          started;
  bit          eb;

  initial begin
    checks = 0;
    errors = 0;
    exp_bits = '{0,0,1,0,1,1,0,1,
                 1,0,0,1,0,1,1,0};
    vecs[0] = '{1'b1, 16'b0010110110010110,
                1'b1, 1'b0, 1'b1, 1'b0,
                1'b1, 8'd0};
    for (int i = 1; i < 16; i++)
      vecs[i] = '{1'b0, 16'h0, 1'b1,
                  1'(exp_bits[i]), 1'b1,
                  (i == 15), 1'b1, 8'd0};
    vecs[16] = '{1'b0, 16'h0, 1'b1, 1'b0,
                 1'b0, 1'b0, 1'b1, 8'd1};

    // reset state
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0);
    step();
    step();
    chk("rst_bv", int'(bus.bit_valid), 0);
    chk("rst_bo", int'(bus.bit_out), 0);
    chk("rst_last", int'(bus.last_bit), 0);
    chk("rst_rdy", int'(bus.load_ready), 1);
    chk("rst_wc", int'(bus.word_count), 0);
    rst = 1'b0;
    step();

    // single word from table
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].lv, vecs[i].d, vecs[i].se);
      step();
      chk($sformatf("vec%0d_bv", i),
          int'(bus.bit_valid), int'(vecs[i].ebv));
      if (vecs[i].ebv)
        chk($sformatf("vec%0d_bo", i),
            int'(bus.bit_out), int'(vecs[i].ebo));
      chk($sformatf("vec%0d_last", i),
          int'(bus.last_bit), int'(vecs[i].elast));
      chk($sformatf("vec%0d_rdy", i),
          int'(bus.load_ready), int'(vecs[i].erdy));
      chk($sformatf("vec%0d_wc", i),
          int'(bus.word_count), int'(vecs[i].ewc));
    end

    // reset mid-word
    drive(1'b1, 16'h2D96, 1'b1);
    step();
    bus.load_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_bv", int'(bus.bit_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_bv", int'(bus.bit_valid), 0);
    chk("arst_bo", int'(bus.bit_out), 0);
    chk("arst_last", int'(bus.last_bit), 0);
    chk("arst_rdy", int'(bus.load_ready), 1);
    chk("arst_wc", int'(bus.word_count), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_idle", int'(bus.bit_valid), 0);
    end
    drive(1'b1, 16'h8000, 1'b1);
    step();
    chk("post_rst_acc", int'(bus.bit_valid), 1);
    chk("post_rst_msb", int'(bus.bit_out), 1);
    bus.load_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // back-to-back words
    w0 = 16'h2D96;
    w1 = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      drive((i < 2), (i == 0) ? w0 : w1, 1'b1);
      step();
      eb = (i < 16) ? w0[15-i] : w1[31-i];
      chk($sformatf("b2b%0d_bv", i),
          int'(bus.bit_valid), 1);
      chk($sformatf("b2b%0d_bo", i),
          int'(bus.bit_out), int'(eb));
      chk($sformatf("b2b%0d_rdy", i),
          int'(bus.load_ready),
          (i >= 1 && i <= 15) ? 0 : 1);
    end
    drive(1'b0, 16'h0, 1'b1);
    step();
    chk("b2b_end_bv", int'(bus.bit_valid), 0);
    chk("b2b_wc", int'(bus.word_count), 2);

    // stall while bit index 9 (a 0) is shown
    w0 = 16'hA5A5;
    drive(1'b1, w0, 1'b1);
    step();
    chk("stall_msb", int'(bus.bit_out), 1);
    pos = 0;
    stalls = 0;
    for (int c = 0; c < 18; c++) begin
      bus.load_valid = 1'b0;
      if (pos == 9 && stalls < 3) begin
        bus.shift_en = 1'b0;
        stalls++;
      end else begin
        bus.shift_en = 1'b1;
        pos++;
      end
      step();
      chk($sformatf("stall%0d_bv", c),
          int'(bus.bit_valid), 1);
      chk($sformatf("stall%0d_bo", c),
          int'(bus.bit_out), int'(w0[15-pos]));
      chk($sformatf("stall%0d_last", c),
          int'(bus.last_bit), (pos == 15) ? 1 : 0);
      if (!bus.shift_en)
        chk("stall_hold0", int'(bus.bit_out), 0);
    end
    bus.shift_en = 1'b1;
    step();
    chk("stall_end_bv", int'(bus.bit_valid), 0);
    chk("stall_wc", int'(bus.word_count), 3);

    // same-cycle reload on last bit
    drive(1'b1, 16'h8000, 1'b1);
    step();
    bus.load_valid = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("sc_a_bv", int'(bus.bit_valid), 1);
      chk("sc_a_bo", int'(bus.bit_out), 0);
    end
    chk("sc_last", int'(bus.last_bit), 1);
    chk("sc_rdy", int'(bus.load_ready), 1);
    drive(1'b1, 16'h0001, 1'b1);
    step();
    chk("sc_b_bv0", int'(bus.bit_valid), 1);
    chk("sc_b_bo0", int'(bus.bit_out), 0);
    chk("sc_b_last0", int'(bus.last_bit), 0);
    chk("sc_wc_mid", int'(bus.word_count), 4);
    bus.load_valid = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("sc_b_bv", int'(bus.bit_valid), 1);
      chk("sc_b_bo", int'(bus.bit_out),
          (i == 15) ? 1 : 0);
      chk("sc_b_rdy", int'(bus.load_ready), 1);
    end
    step();
    chk("sc_end_bv", int'(bus.bit_valid), 0);
    chk("sc_wc", int'(bus.word_count), 5);

    // 256 words: counter wraps to 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    acc = 0;
    lasts = 0;
    gaps = 0;
    seen = 1'b0;
    started = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      drive((acc < 256), 16'(c * 7 + 1), 1'b1);
      if (bus.load_valid && bus.load_ready) acc++;
      if (bus.last_bit) lasts++;
      step();
      if (started && lasts < 256 && !bus.bit_valid)
        gaps++;
      started = 1'b1;
      if (lasts == 255 && !seen) begin
        chk("wrap_wc255",
            int'(bus.word_count), 255);
        seen = 1'b1;
      end
      if (acc == 256 && !bus.bit_valid) break;
    end
    chk("wrap_done_bv", int'(bus.bit_valid), 0);
    chk("wrap_acc", acc, 256);
    chk("wrap_lasts", lasts, 256);
    chk("wrap_gaps", gaps, 0);
    chk("wrap_wc0", int'(bus.word_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
